peg_cmtx_prod_drain: RTL

Receiving end of the signed 16×14 product pipeline in the PEG C-matrix stage. It tracks each operand pair issued into the fixed-latency multiplier and captures the 30-bit product when it emerges. Each product is rounded and saturated to 16 bits and buffered in a small FIFO, then handed downstream over valid/ready. Credit-based issue control guarantees that no in-flight product is ever dropped, even when downstream stalls indefinitely.

---
 rtl/peg_cmtx_prod_drain.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/peg_cmtx_prod_drain.sv
// ---------------------------------------------------------------------------
// peg_cmtx_prod_drain
//
// Receiving end of the signed product pipeline in the PEG C-matrix stage.
// Every accepted operand pair launches a token down a MUL_LAT-deep shift
// register that tracks the fixed-latency multiplier. When a token reaches
// the end, the product on mul_dout is rounded (half-up), saturated to OUT_W
// bits and pushed into a small FIFO that drains over valid/ready.
// Issue is gated by credits: one credit per FIFO slot, taken on accept and
// returned on pop, so an in-flight product always has a slot reserved.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   operand pair present on the multiplier inputs
//   in_ready   out  issue granted (credits available, not in reset)
//   mul_ce     out  multiplier clock enable (low only during reset)
//   mul_dout   in   signed PROD_W-bit product from the multiplier
//   out_data   out  requantized signed result at the FIFO head (0 when empty)
//   out_valid  out  FIFO non-empty
//   out_ready  in   downstream accepts the head entry
//   occupancy  out  number of FIFO entries
//   sat_flag   out  sticky flag, set when any captured product saturated
// ---------------------------------------------------------------------------
module peg_cmtx_prod_drain #(
    parameter int PROD_W     = 30,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 13,
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                mul_ce,
    input  logic signed [PROD_W-1:0]            mul_dout,
    output logic [OUT_W-1:0]                    out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(FIFO_DEPTH):0]         occupancy,
    output logic                                sat_flag
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic signed [PROD_W:0] RND     = (PROD_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [PROD_W:0] SAT_MAX = (PROD_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W:0] SAT_MIN = -SAT_MAX - (PROD_W+1)'(1);

    logic                 accept;
    logic                 pop;
    logic                 push;
    logic [CNT_W-1:0]     credits;
    logic [MUL_LAT-1:0]   tok;
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [OUT_W-1:0]     mem [FIFO_DEPTH];

    logic signed [PROD_W:0] rounded;
    logic signed [PROD_W:0] shifted;
    logic [OUT_W-1:0]       q_data;
    logic                   q_sat;

    // Handshakes. in_ready looks only at registered credits and reset, so
    // out_ready never reaches in_ready combinationally.
    assign in_ready  = (credits != '0) && !reset;
    assign mul_ce    = !reset;
    assign out_valid = (count != '0);
    assign occupancy = count;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push      = tok[MUL_LAT-1];

    // Storage is not reset, so mask the head while empty to keep out_data 0.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Requantize: sign-extend by one bit so the rounding add cannot overflow,
    // then arithmetic shift and clamp to the signed OUT_W range.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rounded = $signed({mul_dout[PROD_W-1], mul_dout}) + RND;
        shifted = rounded >>> SHIFT;
        q_data  = shifted[OUT_W-1:0];
        q_sat   = 1'b0;
        if (shifted > SAT_MAX) begin
            q_data = SAT_MAX[OUT_W-1:0];
            q_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            q_data = SAT_MIN[OUT_W-1:0];
            q_sat  = 1'b1;
        end
    end

    // Credits, token pipeline, pointers and sticky saturation flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits  <= CNT_W'(FIFO_DEPTH);
            tok      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sat_flag <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   credits <= credits + CNT_W'(1);
                default: credits <= credits;
            endcase

            tok[0] <= accept;
            for (int i = 1; i < MUL_LAT; i++) begin
                tok[i] <= tok[i-1];
            end

            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (q_sat) begin
                    sat_flag <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the data array carries no reset; the pointers and count define
    // which entries are meaningful, so clearing them is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q_data;
        end
    end

endmodule
